// File: rtl/lsu_pkg.sv
// lsu_pkg: shared widths, store-buffer depth and store-entry type for the load/store unit.
package lsu_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int RAM_IDX_W = 3;
  localparam int SB_DEPTH = 4;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: pipeline request/response and data-memory port of the load/store unit.
interface load_store_unit_if #(parameter int DATA_W = 16, parameter int ADDR_W = 16);
  logic req_valid, req_ready, req_we, resp_valid, mem_write_en, mem_read, sb_empty;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata, resp_rdata, mem_write_data, mem_read_data;
  logic [15:0] mem_access_addr;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_read_data,
    input req_ready, resp_valid, resp_rdata, mem_access_addr, mem_write_data, mem_write_en, mem_read, sb_empty
  );
  modport slave (
    input req_valid, req_we, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, mem_access_addr, mem_write_data, mem_write_en, mem_read, sb_empty
  );
endinterface

// File: rtl/load_store_unit_store_buffer.sv
// store_buffer: circular store FIFO with per-entry address match and youngest-match data.
module store_buffer
  import lsu_pkg::*;
#(parameter int DEPTH = SB_DEPTH) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  sb_entry_t            wr_entry,
  input  logic [RAM_IDX_W-1:0] match_idx,
  output sb_entry_t            head_entry,
  output logic                 full,
  output logic                 empty,
  output logic                 hit,
  output logic [DATA_W-1:0]    hit_data
);
  localparam int PW = $clog2(DEPTH);
  sb_entry_t entries [DEPTH];
  logic [PW-1:0] head, tail, idx;
  logic [PW:0] count;
  logic [DEPTH-1:0] match;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop) head <= head + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) entries[tail] <= wr_entry;
  // Walk oldest to youngest so the last hit found is the youngest one.
  always_comb begin
    match = '0;
    hit_data = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      match[idx] = ((PW+1)'(i) < count) && (entries[idx].addr[RAM_IDX_W-1:0] == match_idx);
      if (match[idx]) hit_data = entries[idx].data;
    end
  end
  assign hit = |match;
  assign head_entry = entries[head];
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: buffered stores drained to an 8-word RAM, loads served from RAM or the buffer.
// Define LSU_STORE_FWD_EN to forward buffered store data to matching loads instead of stalling.
module load_store_unit #(
  parameter int DATA_W = lsu_pkg::DATA_W,
  parameter int ADDR_W = lsu_pkg::ADDR_W,
  parameter int SB_DEPTH = lsu_pkg::SB_DEPTH
) (
  input logic clk,
  input logic rst_n,
  load_store_unit_if.slave bus
);
  import lsu_pkg::*;
`ifdef LSU_STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic full, empty, hit, ready, load_acc, store_acc, use_mem, drain;
  logic [DATA_W-1:0] hit_data;
  sb_entry_t head_entry, wr_entry;
  assign wr_entry = '{addr: bus.req_addr, data: bus.req_wdata};
  store_buffer #(.DEPTH(SB_DEPTH)) u_sb (
    .clk(clk), .rst_n(rst_n), .push(store_acc), .pop(drain), .wr_entry(wr_entry),
    .match_idx(bus.req_addr[RAM_IDX_W-1:0]), .head_entry(head_entry), .full(full),
    .empty(empty), .hit(hit), .hit_data(hit_data)
  );
  // A load accepted this cycle owns the memory port, even when forwarded.
  always_comb begin
    ready = rst_n & (bus.req_we ? !full : (FWD || !hit));
    load_acc = bus.req_valid & !bus.req_we & ready;
    store_acc = bus.req_valid & bus.req_we & ready;
    use_mem = load_acc & !(FWD && hit);
    drain = !empty & !load_acc;
    bus.req_ready = ready;
    bus.mem_read = use_mem;
    bus.mem_write_en = drain;
    bus.mem_access_addr = use_mem ? 16'(bus.req_addr) : drain ? 16'(head_entry.addr) : '0;
    bus.mem_write_data = drain ? head_entry.data : '0;
    bus.sb_empty = empty;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
    end else begin
      bus.resp_valid <= load_acc;
      if (load_acc) bus.resp_rdata <= (FWD && hit) ? hit_data : bus.mem_read_data;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random stimulus against an architectural memory/queue model.
module tb_load_store_unit;
  localparam int SB_DEPTH = 4;
`ifdef LSU_STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  typedef struct {logic [15:0] a; logic [15:0] d;} pend_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int compared = 0;
  int mismatched = 0;
  logic [15:0] ram [8];
  logic [15:0] mem_model [8];
  logic [15:0] arch [8];
  pend_t q [$];
  logic dummy;
  load_store_unit_if #(.DATA_W(16), .ADDR_W(16)) bus ();
  load_store_unit #(.DATA_W(16), .ADDR_W(16), .SB_DEPTH(SB_DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.mem_read_data = ram[bus.mem_access_addr[2:0]];
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive a request, check the port against the model, then the response.
  task automatic cyc(input logic v, input logic we, input logic [15:0] a, input logic [15:0] d, output logic acc);
    logic match, ready, ld, rd, wr, s_we;
    logic [15:0] exp_addr, exp_wdata, exp_load, s_addr, s_data;
    pend_t h;
    bus.req_valid = v;
    bus.req_we = we;
    bus.req_addr = a;
    bus.req_wdata = d;
    #1;
    match = 1'b0;
    foreach (q[i]) if (q[i].a[2:0] == a[2:0]) match = 1'b1;
    if (q.size() != 0) h = q[0];
    else h = '{16'h0, 16'h0};
    ready = we ? (q.size() < SB_DEPTH) : (FWD || !match);
    acc = v && ready;
    ld = acc && !we;
    rd = ld && !(FWD && match);
    wr = (q.size() != 0) && !ld;
    exp_addr = rd ? a : wr ? h.a : 16'h0;
    exp_wdata = wr ? h.d : 16'h0;
    exp_load = arch[a[2:0]];
    chk("req_ready", 32'(bus.req_ready), 32'(ready));
    chk("mem_read", 32'(bus.mem_read), 32'(rd));
    chk("mem_write_en", 32'(bus.mem_write_en), 32'(wr));
    chk("mem_access_addr", 32'(bus.mem_access_addr), 32'(exp_addr));
    chk("mem_write_data", 32'(bus.mem_write_data), 32'(exp_wdata));
    chk("sb_empty", 32'(bus.sb_empty), 32'(q.size() == 0));
    s_we = bus.mem_write_en;
    s_addr = bus.mem_access_addr;
    s_data = bus.mem_write_data;
    @(posedge clk);
    if (s_we) ram[s_addr[2:0]] = s_data;
    if (wr) begin
      mem_model[h.a[2:0]] = h.d;
      void'(q.pop_front());
    end
    if (acc && we) begin
      q.push_back('{a, d});
      arch[a[2:0]] = d;
    end
    #1;
    chk("resp_valid", 32'(bus.resp_valid), 32'(ld));
    if (ld) chk("resp_rdata", 32'(bus.resp_rdata), 32'(exp_load));
  endtask

  task automatic load_until(input logic [15:0] a);
    logic acc = 1'b0;
    for (int n = 0; n < 10 && !acc; n++) cyc(1'b1, 1'b0, a, 16'h0, acc);
    chk("load_accept", 32'(acc), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we = 1'b0;
    bus.req_addr = 16'h0003;
    bus.req_wdata = 16'h0;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst_mem_write_en", 32'(bus.mem_write_en), 32'd0);
    chk("rst_mem_access_addr", 32'(bus.mem_access_addr), 32'd0);
    chk("rst_mem_write_data", 32'(bus.mem_write_data), 32'd0);
    chk("rst_sb_empty", 32'(bus.sb_empty), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", 32'(bus.resp_rdata), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    arch = mem_model;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      ram[i] = 16'($urandom);
      mem_model[i] = ram[i];
    end
    arch = mem_model;
    do_reset();
    // Single store drains on the following idle cycle.
    cyc(1'b1, 1'b1, 16'h0002, 16'h1234, dummy);
    cyc(1'b0, 1'b0, 16'h0000, 16'h0000, dummy);
    cyc(1'b0, 1'b0, 16'h0000, 16'h0000, dummy);
    chk("ram2_1234", 32'(ram[2]), 32'h1234);
    // Load through an aliased address.
    cyc(1'b1, 1'b1, 16'h0003, 16'h00AA, dummy);
    cyc(1'b0, 1'b0, 16'h0000, 16'h0000, dummy);
    load_until(16'h000B);
    chk("alias_rdata", 32'(bus.resp_rdata), 32'h00AA);
    // Store followed immediately by a load to the same word.
    cyc(1'b1, 1'b1, 16'h0003, 16'hBEEF, dummy);
    load_until(16'h0003);
    chk("raw_rdata", 32'(bus.resp_rdata), 32'hBEEF);
    // Two stores to one word then a load of it.
    cyc(1'b1, 1'b1, 16'h0001, 16'h0001, dummy);
    cyc(1'b1, 1'b1, 16'h0001, 16'h0002, dummy);
    load_until(16'h0001);
    chk("youngest_rdata", 32'(bus.resp_rdata), 32'h0002);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0, 16'h0, dummy);
    chk("ram1_0002", 32'(ram[1]), 32'h0002);
    // Back-to-back loads hold off the drain of a pending store.
    cyc(1'b1, 1'b1, 16'h0005, 16'h5555, dummy);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 16'h0007, 16'h0, dummy);
    cyc(1'b0, 1'b0, 16'h0, 16'h0, dummy);
    chk("ram5_5555", 32'(ram[5]), 32'h5555);
    // Reset with stores pending discards them.
    cyc(1'b1, 1'b1, 16'h0004, 16'hAAAA, dummy);
    cyc(1'b1, 1'b0, 16'h0007, 16'h0, dummy);
    cyc(1'b1, 1'b1, 16'h0006, 16'hBBBB, dummy);
    cyc(1'b1, 1'b0, 16'h0007, 16'h0, dummy);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0, 16'h0, dummy);
    chk("ram6_kept", 32'(ram[6]), 32'(mem_model[6]));
    // Random traffic.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), dummy);
    for (int i = 0; i < 10 && q.size() != 0; i++) cyc(1'b0, 1'b0, 16'h0, 16'h0, dummy);
    chk("final_sb_empty", 32'(bus.sb_empty), 32'd1);
    for (int i = 0; i < 8; i++) chk("final_ram", 32'(ram[i]), 32'(mem_model[i]));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
